// File: rtl/hbridge_pkg.sv
// rtl/hbridge_pkg.sv - shared types and default widths for the H-bridge PWM block
package hbridge_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DT_W_DEF  = 4;

    typedef enum logic [1:0] {
        LEG_OFF   = 2'd0,
        LEG_DRIVE = 2'd1,
        LEG_DEAD  = 2'd2
    } leg_state_t;

endpackage

// File: rtl/hbridge_leg_deadtime.sv
// rtl/hbridge_leg_deadtime.sv - one half-bridge leg FSM with dead-time float insertion
module hbridge_leg_deadtime
    import hbridge_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            target,
    input  logic [DT_W-1:0] dead_time,
    output logic            leg_in,
    output logic            leg_en_n
);

    leg_state_t      state;
    logic [DT_W-1:0] dt_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LEG_OFF;
            leg_in   <= 1'b0;
            leg_en_n <= 1'b1;
            dt_cnt   <= '0;
        end else if (!enable) begin
            // Floating is always safe, so any pending dead time is simply dropped.
            state    <= LEG_OFF;
            leg_in   <= 1'b0;
            leg_en_n <= 1'b1;
        end else begin
            case (state)
                LEG_OFF: begin
                    state    <= LEG_DRIVE;
                    leg_in   <= target;
                    leg_en_n <= 1'b0;
                end
                LEG_DRIVE: begin
                    if (target != leg_in) begin
                        if (dead_time != '0) begin
                            state    <= LEG_DEAD;
                            leg_en_n <= 1'b1;
                            dt_cnt   <= dead_time;
                        end else begin
                            leg_in <= target;
                        end
                    end
                end
                LEG_DEAD: begin
                    // Target is resampled on exit; it may have reverted to the old level.
                    if (dt_cnt <= DT_W'(1)) begin
                        state    <= LEG_DRIVE;
                        leg_in   <= target;
                        leg_en_n <= 1'b0;
                    end else begin
                        dt_cnt <= dt_cnt - DT_W'(1);
                    end
                end
                default: begin
                    state    <= LEG_OFF;
                    leg_in   <= 1'b0;
                    leg_en_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/hbridge_pwm_deadtime.sv
// rtl/hbridge_pwm_deadtime.sv - H-bridge PWM: shadowed settings, period counter, leg targets
module hbridge_pwm_deadtime
    import hbridge_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DT_W  = DT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             brake,
    input  logic             update,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             dir,
    input  logic [DT_W-1:0]  dead_time,
    output logic             in_a,
    output logic             en_n_a,
    output logic             in_b,
    output logic             en_n_b,
    output logic             cycle_start,
    output logic             pending
);

    logic [CNT_W-1:0] pend_period, pend_duty, act_period, act_duty, cnt;
    logic [DT_W-1:0]  pend_dt, act_dt;
    logic             pend_dir, act_dir;
    logic             wrap, apply, sw_high, tgt_a, tgt_b;

    // A zero period parks the counter at 0; treating that as a wrap every
    // cycle lets a new non-zero setting still be applied while running.
    assign wrap  = (act_period == '0) || (cnt >= act_period - CNT_W'(1));
    assign apply = pending && (!enable || wrap);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_period <= '0;
            pend_duty   <= '0;
            pend_dt     <= '0;
            pend_dir    <= 1'b0;
            act_period  <= '0;
            act_duty    <= '0;
            act_dt      <= '0;
            act_dir     <= 1'b0;
            pending     <= 1'b0;
            cnt         <= '0;
        end else begin
            if (apply) begin
                act_period <= pend_period;
                act_duty   <= pend_duty;
                act_dt     <= pend_dt;
                act_dir    <= pend_dir;
            end
            if (update) begin
                pend_period <= period;
                pend_duty   <= duty;
                pend_dt     <= dead_time;
                pend_dir    <= dir;
                pending     <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
            cnt <= (!enable || wrap) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign cycle_start = enable && (cnt == '0);

    assign sw_high = (act_period != '0) && (cnt < act_duty);
    assign tgt_a   = !brake && !act_dir && sw_high;
    assign tgt_b   = !brake &&  act_dir && sw_high;

    hbridge_leg_deadtime #(.DT_W(DT_W)) u_leg_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .target    (tgt_a),
        .dead_time (act_dt),
        .leg_in    (in_a),
        .leg_en_n  (en_n_a)
    );

    hbridge_leg_deadtime #(.DT_W(DT_W)) u_leg_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .target    (tgt_b),
        .dead_time (act_dt),
        .leg_in    (in_b),
        .leg_en_n  (en_n_b)
    );

endmodule

// File: tb/tb_hbridge_pwm_deadtime.sv
// tb/tb_hbridge_pwm_deadtime.sv - scoreboard bench for hbridge_pwm_deadtime
module tb_hbridge_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst_n, enable, brake, update, dir;
    logic [7:0] period, duty;
    logic [3:0] dead_time;
    logic       in_a, en_n_a, in_b, en_n_b, cycle_start, pending;

    hbridge_pwm_deadtime dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .brake       (brake),
        .update      (update),
        .period      (period),
        .duty        (duty),
        .dir         (dir),
        .dead_time   (dead_time),
        .in_a        (in_a),
        .en_n_a      (en_n_a),
        .in_b        (in_b),
        .en_n_b      (en_n_b),
        .cycle_start (cycle_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // Expected word: {cycle_start, pending, in_a, en_n_a, in_b, en_n_b}
    typedef struct {
        int         cyc;
        logic [5:0] val;
        string      name;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         cyc = 0;
    int         base = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] act;

    localparam int C = 2;

    logic [5:0] fwd_tab  [21];
    logic [5:0] zdt_tab  [16];
    logic [5:0] dir_tab  [13];
    logic [5:0] brk_tab  [13];
    logic [5:0] edge_tab [10];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            cur = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: check for cycle %0d never sampled (now %0d)", cur.name, cur.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            cur = sb.pop_front();
            act = {cycle_start, pending, in_a, en_n_a, in_b, en_n_b};
            n_cmp++;
            if (act !== cur.val) begin
                n_err++;
                $display("FAIL %s @k=%0d: got {cs,pend,in_a,en_n_a,in_b,en_n_b}=%b want %b",
                         cur.name, cur.cyc - base, act, cur.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int k);
        while (cyc < base + k) tick();
    endtask

    task automatic push(input int k, input logic [5:0] v, input string nm);
        exp_t e;
        e.cyc  = base + k;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic load(input logic [7:0] p, input logic [7:0] d, input logic r, input logic [3:0] t);
        period    = p;
        duty      = d;
        dir       = r;
        dead_time = t;
        update    = 1'b1;
    endtask

    initial begin
        fwd_tab  = '{6'b100101, 6'b001000, 6'b001000, 6'b001000, 6'b001100, 6'b001100,
                     6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b000100,
                     6'b000100, 6'b001000, 6'b001100, 6'b001100, 6'b000000, 6'b000000,
                     6'b000000, 6'b000000, 6'b100000};
        zdt_tab  = '{6'b100000, 6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b000000,
                     6'b000000, 6'b000000, 6'b100000, 6'b001000, 6'b001000, 6'b001000,
                     6'b001000, 6'b000000, 6'b000000, 6'b000000};
        dir_tab  = '{6'b011000, 6'b010000, 6'b010000, 6'b010000, 6'b100000, 6'b000001,
                     6'b000001, 6'b000010, 6'b000010, 6'b000011, 6'b000011, 6'b000000,
                     6'b100000};
        brk_tab  = '{6'b100000, 6'b000100, 6'b000100, 6'b000100, 6'b001000, 6'b001000,
                     6'b001100, 6'b001100, 6'b101100, 6'b000000, 6'b000000, 6'b000100,
                     6'b000101};
        edge_tab = '{6'b010101, 6'b100101, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                     6'b000000, 6'b000000, 6'b000000, 6'b100000};

        rst_n = 1'b0; enable = 1'b0; brake = 1'b0; update = 1'b0;
        period = '0; duty = '0; dir = 1'b0; dead_time = '0;
        repeat (3) tick();
        base = cyc;
        push(0, 6'b000101, "reset");
        rst_n = 1'b1;
        tick();

        base = cyc;
        push(1, 6'b010101, "fwd_pending");
        for (int i = 0; i < 21; i++) push(C + i, fwd_tab[i], "fwd");
        push(C + 22, 6'b010100, "zdt_pending");
        push(C + 29, 6'b010000, "zdt_prewrap");
        for (int i = 0; i < 16; i++) push(C + 30 + i, zdt_tab[i], "zero_dt");
        for (int i = 0; i < 13; i++) push(C + 50 + i, dir_tab[i], "dir_rev");
        push(C + 63, 6'b010001, "brk_pending");
        for (int i = 0; i < 13; i++) push(C + 70 + i, brk_tab[i], "brake_dis");
        for (int i = 0; i < 10; i++) push(C + 83 + i, edge_tab[i], "duty0");
        push(C + 93, 6'b010000, "per0_pending");
        for (int i = 0; i < 5; i++) push(C + 100 + i, 6'b100000, "period0");

        load(8'd10, 8'd3, 1'b0, 4'd2);
        wait_to(1);      update = 1'b0;
        wait_to(C);      enable = 1'b1;
        wait_to(C + 21); load(8'd8, 8'd4, 1'b0, 4'd0);
        wait_to(C + 22); update = 1'b0;
        wait_to(C + 49); load(8'd8, 8'd4, 1'b1, 4'd2);
        wait_to(C + 50); update = 1'b0;
        wait_to(C + 62); load(8'd8, 8'd8, 1'b0, 4'd3);
        wait_to(C + 63); update = 1'b0;
        wait_to(C + 75); brake = 1'b1;
        wait_to(C + 80); brake = 1'b0;
        wait_to(C + 81); enable = 1'b0;
        wait_to(C + 82); load(8'd8, 8'd0, 1'b0, 4'd1);
        wait_to(C + 83); update = 1'b0;
        wait_to(C + 84); enable = 1'b1;
        wait_to(C + 92); load(8'd0, 8'd5, 1'b0, 4'd1);
        wait_to(C + 93); update = 1'b0;
        wait_to(C + 105);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d checks left unsampled, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
